// File: rtl/led_scan_pkg.sv
// Shared definitions for the HUB75 scan driver: scan FSM states, half tags, brightness step.
package led_scan_pkg;

   typedef enum logic [2:0] {
      SHIFT   = 3'd0,
      DRAIN   = 3'd1,
      BLANK   = 3'd2,
      LATCH   = 3'd3,
      UNBLANK = 3'd4
   } scan_state_e;

   localparam logic HALF_TOP    = 1'b0;
   localparam logic HALF_BOTTOM = 1'b1;
   localparam int   BRIGHT_STEP = 16;

endpackage

// File: rtl/led_scan_driver_if.sv
// Painter request/response and panel pin bundle for led_scan_driver.
// brightness exists only when LED_SCAN_BRIGHTNESS_EN is defined.
interface led_scan_driver_if #(
   parameter int FRAME_BITS = 13
);
   logic [FRAME_BITS-1:0] frame;
   logic [5:0]            x;
   logic [5:0]            y;
   logic [2:0]            rgb;
   logic [2:0]            panel_rgb0;
   logic [2:0]            panel_rgb1;
   logic [4:0]            panel_addr;
   logic                  panel_clk;
   logic                  panel_lat;
   logic                  panel_oe_n;
`ifdef LED_SCAN_BRIGHTNESS_EN
   logic [2:0]            brightness;
`endif

   modport master (
      input  rgb,
`ifdef LED_SCAN_BRIGHTNESS_EN
      input  brightness,
`endif
      output frame, x, y, panel_rgb0, panel_rgb1, panel_addr,
             panel_clk, panel_lat, panel_oe_n
   );

   modport slave (
      output rgb,
`ifdef LED_SCAN_BRIGHTNESS_EN
      output brightness,
`endif
      input  frame, x, y, panel_rgb0, panel_rgb1, panel_addr,
             panel_clk, panel_lat, panel_oe_n
   );
endinterface

// File: rtl/led_scan_tag_pipe.sv
// Delays the {valid, half, col_last} request tag so it lines up with the painter's rgb response.
module led_scan_tag_pipe #(
   parameter int LATENCY = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_vld,
   input  logic in_half,
   input  logic in_last,
   output logic out_vld,
   output logic out_half,
   output logic out_last
);
   generate
      if (LATENCY == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign out_vld  = in_vld;
         assign out_half = in_half;
         assign out_last = in_last;
      end else begin : g_pipe
         logic [LATENCY-1:0][2:0] stage_q, stage_d;

         always_comb begin
            stage_d[0] = {in_vld, in_half, in_last};
            for (int i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) stage_q <= '0;
            else     stage_q <= stage_d;
         end

         assign {out_vld, out_half, out_last} = stage_q[LATENCY-1];
      end
   endgenerate
endmodule

// File: rtl/led_scan_driver.sv
// HUB75 64x64 1/32-scan initiator: requests top/bottom pixels from a painter, shifts, latches, advances rows.
// Defining LED_SCAN_BRIGHTNESS_EN adds a per-row on-time limit driven by bus.brightness.
module led_scan_driver
   import led_scan_pkg::*;
#(
   parameter int WIDTH           = 64,
   parameter int ROWS            = 32,
   parameter int PAINTER_LATENCY = 0,
   parameter int FRAME_BITS      = 13
) (
   input logic               clk,
   input logic               reset,
   led_scan_driver_if.master bus
);
   localparam logic [6:0] LAST_REQ = 7'(2*WIDTH - 1);
   localparam logic [5:0] LAST_COL = 6'(WIDTH - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [5:0] ROW_OFS  = 6'(ROWS);

   scan_state_e           state_q, state_d;
   logic [6:0]            cnt_q, cnt_d, cnt_nxt;
   logic [4:0]            row_q, row_d, row_nxt;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic                  first_pass_q, first_pass_d;
   logic [5:0]            x_q, x_d, y_q, y_d;
   logic                  req_vld_q, req_vld_d, req_half_q, req_half_d, req_last_q, req_last_d;
   logic [2:0]            shadow_q, shadow_d, rgb0_q, rgb0_d, rgb1_q, rgb1_d;
   logic                  pend_q, pend_d, pend_last_q, pend_last_d;
   logic                  clk_q, clk_d, clk_last_q, clk_last_d;
   logic                  lat_q, lat_d, oe_n_q, oe_n_d;
   logic [4:0]            addr_q, addr_d;
   logic                  active_d;
   logic                  tag_vld, tag_half, tag_last;
`ifdef LED_SCAN_BRIGHTNESS_EN
   logic [7:0]            on_q, on_d;
`endif

   led_scan_tag_pipe #(.LATENCY(PAINTER_LATENCY)) u_tag_pipe (
      .clk      (clk),
      .rst      (reset),
      .in_vld   (req_vld_q),
      .in_half  (req_half_q),
      .in_last  (req_last_q),
      .out_vld  (tag_vld),
      .out_half (tag_half),
      .out_last (tag_last)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cnt_nxt      = cnt_q + 7'd1;
      row_d        = row_q;
      row_nxt      = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
      frame_d      = frame_q;
      first_pass_d = first_pass_q;
      x_d          = x_q;
      y_d          = y_q;
      req_vld_d    = 1'b0;
      req_half_d   = req_half_q;
      req_last_d   = req_last_q;
      shadow_d     = shadow_q;
      rgb0_d       = rgb0_q;
      rgb1_d       = rgb1_q;
      pend_d       = 1'b0;
      pend_last_d  = 1'b0;
      addr_d       = addr_q;
      lat_d        = 1'b0;
      // A bottom capture is followed by one low and one high panel_clk cycle.
      clk_d        = pend_q;
      clk_last_d   = pend_last_q;

      if (tag_vld) begin
         if (tag_half == HALF_TOP) begin
            shadow_d = bus.rgb;
         end else begin
            rgb0_d      = shadow_q;
            rgb1_d      = bus.rgb;
            pend_d      = 1'b1;
            pend_last_d = tag_last;
         end
      end

      case (state_q)
         SHIFT: begin
            if (cnt_q == LAST_REQ) begin
               state_d = DRAIN;
            end else begin
               cnt_d      = cnt_nxt;
               x_d        = cnt_nxt[6:1];
               y_d        = {1'b0, row_q} + (cnt_nxt[0] ? ROW_OFS : 6'd0);
               req_vld_d  = 1'b1;
               req_half_d = cnt_nxt[0] ? HALF_BOTTOM : HALF_TOP;
               req_last_d = (cnt_nxt[6:1] == LAST_COL);
            end
         end
         DRAIN: begin
            if (clk_q && clk_last_q) state_d = BLANK;
         end
         BLANK: begin
            state_d = LATCH;
            lat_d   = 1'b1;
            addr_d  = row_q;
         end
         LATCH: begin
            state_d      = UNBLANK;
            first_pass_d = 1'b0;
         end
         UNBLANK: begin
            state_d    = SHIFT;
            cnt_d      = 7'd0;
            row_d      = row_nxt;
            if (row_q == LAST_ROW) frame_d = frame_q + FRAME_BITS'(1);
            x_d        = 6'd0;
            y_d        = {1'b0, row_nxt};
            req_vld_d  = 1'b1;
            req_half_d = HALF_TOP;
            req_last_d = (WIDTH == 1);
         end
         default: state_d = SHIFT;
      endcase

      active_d = (state_d == SHIFT) || (state_d == DRAIN);
`ifdef LED_SCAN_BRIGHTNESS_EN
      // On-time budget counts down from the first SHIFT cycle; leaving DRAIN clamps it.
      if (state_q == UNBLANK)  on_d = 8'((int'(bus.brightness) + 1) * BRIGHT_STEP);
      else if (on_q != 8'd0)   on_d = on_q - 8'd1;
      else                     on_d = on_q;
      oe_n_d = first_pass_d || !active_d || (on_d == 8'd0);
`else
      oe_n_d = first_pass_d || !active_d;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= SHIFT;
         cnt_q        <= 7'd0;
         row_q        <= 5'd0;
         frame_q      <= '0;
         first_pass_q <= 1'b1;
         x_q          <= 6'd0;
         y_q          <= 6'd0;
         req_vld_q    <= 1'b1;
         req_half_q   <= HALF_TOP;
         req_last_q   <= (WIDTH == 1);
         shadow_q     <= 3'd0;
         rgb0_q       <= 3'd0;
         rgb1_q       <= 3'd0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         clk_q        <= 1'b0;
         clk_last_q   <= 1'b0;
         lat_q        <= 1'b0;
         oe_n_q       <= 1'b1;
         addr_q       <= 5'd0;
`ifdef LED_SCAN_BRIGHTNESS_EN
         on_q         <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         frame_q      <= frame_d;
         first_pass_q <= first_pass_d;
         x_q          <= x_d;
         y_q          <= y_d;
         req_vld_q    <= req_vld_d;
         req_half_q   <= req_half_d;
         req_last_q   <= req_last_d;
         shadow_q     <= shadow_d;
         rgb0_q       <= rgb0_d;
         rgb1_q       <= rgb1_d;
         pend_q       <= pend_d;
         pend_last_q  <= pend_last_d;
         clk_q        <= clk_d;
         clk_last_q   <= clk_last_d;
         lat_q        <= lat_d;
         oe_n_q       <= oe_n_d;
         addr_q       <= addr_d;
`ifdef LED_SCAN_BRIGHTNESS_EN
         on_q         <= on_d;
`endif
      end
   end

   assign bus.frame      = frame_q;
   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.panel_rgb0 = rgb0_q;
   assign bus.panel_rgb1 = rgb1_q;
   assign bus.panel_addr = addr_q;
   assign bus.panel_clk  = clk_q;
   assign bus.panel_lat  = lat_q;
   assign bus.panel_oe_n = oe_n_q;
endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver: default geometry, a latency-3 painter and a tiny 4x2 panel with 2-bit frame.
// Expected panel timing is derived per cycle from the row timeline (row period 2*WIDTH+LATENCY+5).
module tb_led_scan_driver;
   logic clk;
   logic reset;
   logic mode0;
   logic [2:0] dly1 [3];

   int n_cmp, n_bad, t;
   int e0_xy, e0_lat, e0_oe, e0_clk, e0_dat, e0_frm, rise0;
   int e1_lat, e1_oe, e1_clk, e1_dat, e1_frm;
   int e2_xy, e2_lat, e2_oe, e2_clk, e2_frm, wrap2;
   logic prev0;
   logic [1:0] prevf2;
   int bon0, bon1, bon2;

   led_scan_driver_if #(.FRAME_BITS(13)) bus0();
   led_scan_driver_if #(.FRAME_BITS(13)) bus1();
   led_scan_driver_if #(.FRAME_BITS(2))  bus2();

   led_scan_driver #(.WIDTH(64), .ROWS(32), .PAINTER_LATENCY(0), .FRAME_BITS(13))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));
   led_scan_driver #(.WIDTH(64), .ROWS(32), .PAINTER_LATENCY(3), .FRAME_BITS(13))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));
   led_scan_driver #(.WIDTH(4), .ROWS(2), .PAINTER_LATENCY(0), .FRAME_BITS(2))
      dut2 (.clk(clk), .reset(reset), .bus(bus2));

   // Painters: dut0 combinational, dut1 three cycles late, dut2 trivial.
   assign bus0.rgb = mode0 ? ((bus0.y < 6'd32) ? 3'b001 : 3'b100) : bus0.x[2:0];
   always @(posedge clk) begin
      dly1[0] <= {bus1.y[0], bus1.x[1:0]};
      dly1[1] <= dly1[0];
      dly1[2] <= dly1[1];
   end
   assign bus1.rgb = dly1[2];
   assign bus2.rgb = bus2.x[2:0];

`ifdef LED_SCAN_BRIGHTNESS_EN
   assign bus0.brightness = 3'd1;
   assign bus1.brightness = 3'd7;
   assign bus2.brightness = 3'd0;
   initial begin bon0 = 32; bon1 = 128; bon2 = 16; end
`else
   initial begin bon0 = 1000; bon1 = 1000; bon2 = 1000; end
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      e0_xy = 0; e0_lat = 0; e0_oe = 0; e0_clk = 0; e0_dat = 0; e0_frm = 0; rise0 = 0;
      e1_lat = 0; e1_oe = 0; e1_clk = 0; e1_dat = 0; e1_frm = 0;
      e2_xy = 0; e2_lat = 0; e2_oe = 0; e2_clk = 0; e2_frm = 0; wrap2 = 0;
      prev0 = 1'b0; prevf2 = 2'd0;
   endtask

   task automatic step_check();
      int r, p, c, ex, ey;
      logic ecl, eoe;
      logic [2:0] ed;
      // dut0: period 133, clk high on odd p in 3..129, latch at 131
      r = t / 133; p = t % 133;
      if (p < 130) begin
         ex = (p < 128) ? p / 2 : 63;
         ey = (r % 32) + (((p < 128) ? (p % 2) : 1) == 1 ? 32 : 0);
         if (bus0.x !== 6'(ex) || bus0.y !== 6'(ey)) e0_xy++;
      end
      if (bus0.panel_lat !== (p == 131)) e0_lat++;
      if (p == 131 && bus0.panel_addr !== 5'(r % 32)) e0_lat++;
      if (bus0.panel_lat && (bus0.panel_clk || !bus0.panel_oe_n)) e0_lat++;
      eoe = (r == 0) ? 1'b1 : ((p < ((bon0 < 130) ? bon0 : 130)) ? 1'b0 : 1'b1);
      if (bus0.panel_oe_n !== eoe) e0_oe++;
      ecl = (p >= 3 && p <= 129 && (p % 2) == 1);
      if (bus0.panel_clk !== ecl) e0_clk++;
      if (ecl) begin
         c = (p - 3) / 2;
         ed = c[2:0];
         if (r == 0 && (bus0.panel_rgb0 !== ed || bus0.panel_rgb1 !== ed)) e0_dat++;
         if (r != 0 && (bus0.panel_rgb0 !== 3'b001 || bus0.panel_rgb1 !== 3'b100)) e0_dat++;
      end
      if (bus0.frame !== 13'(r / 32)) e0_frm++;
      if (bus0.panel_clk && !prev0) rise0++;
      prev0 = bus0.panel_clk;
      if (p == 0) mode0 = (r != 0);

      // dut1: period 136, clk high on even p in 6..132, latch at 134
      r = t / 136; p = t % 136;
      if (bus1.panel_lat !== (p == 134)) e1_lat++;
      if (p == 134 && bus1.panel_addr !== 5'(r % 32)) e1_lat++;
      eoe = (r == 0) ? 1'b1 : ((p < ((bon1 < 133) ? bon1 : 133)) ? 1'b0 : 1'b1);
      if (bus1.panel_oe_n !== eoe) e1_oe++;
      ecl = (p >= 6 && p <= 132 && (p % 2) == 0);
      if (bus1.panel_clk !== ecl) e1_clk++;
      if (ecl) begin
         c = (p - 6) / 2;
         ed = {r[0], c[1:0]};
         if (bus1.panel_rgb0 !== ed || bus1.panel_rgb1 !== ed) e1_dat++;
      end
      if (bus1.frame !== 13'(r / 32)) e1_frm++;

      // dut2: period 13, clk high on odd p in 3..9, latch at 11
      r = t / 13; p = t % 13;
      if (p < 10) begin
         ex = (p < 8) ? p / 2 : 3;
         ey = (r % 2) + (((p < 8) ? (p % 2) : 1) == 1 ? 2 : 0);
         if (bus2.x !== 6'(ex) || bus2.y !== 6'(ey)) e2_xy++;
      end
      if (bus2.panel_lat !== (p == 11)) e2_lat++;
      if (p == 11 && bus2.panel_addr !== 5'(r % 2)) e2_lat++;
      eoe = (r == 0) ? 1'b1 : ((p < ((bon2 < 10) ? bon2 : 10)) ? 1'b0 : 1'b1);
      if (bus2.panel_oe_n !== eoe) e2_oe++;
      if (bus2.panel_clk !== (p >= 3 && p <= 9 && (p % 2) == 1)) e2_clk++;
      if (bus2.frame !== 2'((r / 2) % 4)) e2_frm++;
      if (prevf2 == 2'd3 && bus2.frame == 2'd0) wrap2++;
      prevf2 = bus2.frame;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         t = i;
         step_check();
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; t = 0;
      mode0 = 1'b0;
      reset = 1'b1;
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oe_n", 32'(bus0.panel_oe_n), 32'd1);
      chk("rst_clk", 32'(bus0.panel_clk), 32'd0);
      chk("rst_lat", 32'(bus0.panel_lat), 32'd0);
      chk("rst_addr", 32'(bus0.panel_addr), 32'd0);
      chk("rst_xy", 32'({bus0.x, bus0.y}), 32'd0);
      chk("rst_frame", 32'(bus0.frame), 32'd0);
      chk("rst_rgb", 32'({bus0.panel_rgb0, bus0.panel_rgb1}), 32'd0);

      // Run 34 rows of the default panel from reset release.
      reset = 1'b0;
      #1;
      run_cycles(4522);
      chk("d0_req_xy", 32'(e0_xy), 32'd0);
      chk("d0_lat_addr", 32'(e0_lat), 32'd0);
      chk("d0_oe_n", 32'(e0_oe), 32'd0);
      chk("d0_pclk", 32'(e0_clk), 32'd0);
      chk("d0_data", 32'(e0_dat), 32'd0);
      chk("d0_frame", 32'(e0_frm), 32'd0);
      chk("d0_rises", 32'(rise0), 32'd2176);
      chk("d0_frame_end", 32'(bus0.frame), 32'd1);
      chk("d1_lat_addr", 32'(e1_lat), 32'd0);
      chk("d1_oe_n", 32'(e1_oe), 32'd0);
      chk("d1_pclk", 32'(e1_clk), 32'd0);
      chk("d1_data", 32'(e1_dat), 32'd0);
      chk("d1_frame", 32'(e1_frm), 32'd0);
      chk("d2_req_xy", 32'(e2_xy), 32'd0);
      chk("d2_lat_addr", 32'(e2_lat), 32'd0);
      chk("d2_oe_n", 32'(e2_oe), 32'd0);
      chk("d2_pclk", 32'(e2_clk), 32'd0);
      chk("d2_frame", 32'(e2_frm), 32'd0);
      chk("d2_wraps", 32'(wrap2), 32'd43);

      // Restart, then hit reset at row 5 column 20 (top request).
      @(posedge clk);
      #1;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      clear_counts();
      run_cycles(705);
      chk("r5_run_xy", 32'(e0_xy), 32'd0);
      chk("r5_run_oe", 32'(e0_oe), 32'd0);
      @(posedge clk);
      #1;
      chk("pre_rst_x", 32'(bus0.x), 32'd20);
      chk("pre_rst_y", 32'(bus0.y), 32'd5);
      chk("pre_rst_addr", 32'(bus0.panel_addr), 32'd4);
      reset = 1'b1;
      #1;
      chk("mid_oe_n", 32'(bus0.panel_oe_n), 32'd1);
      chk("mid_clk", 32'(bus0.panel_clk), 32'd0);
      chk("mid_lat", 32'(bus0.panel_lat), 32'd0);
      chk("mid_addr", 32'(bus0.panel_addr), 32'd0);
      chk("mid_xy", 32'({bus0.x, bus0.y}), 32'd0);
      chk("mid_frame", 32'(bus0.frame), 32'd0);
      chk("mid_d1_oe_n", 32'(bus1.panel_oe_n), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      clear_counts();
      run_cycles(140);
      chk("re_req_xy", 32'(e0_xy), 32'd0);
      chk("re_lat_addr", 32'(e0_lat), 32'd0);
      chk("re_oe_n", 32'(e0_oe), 32'd0);
      chk("re_pclk", 32'(e0_clk), 32'd0);
      chk("re_data", 32'(e0_dat), 32'd0);
      chk("re_rises", 32'(rise0), 32'd66);
      chk("re_d1_pclk", 32'(e1_clk), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
